// File: rtl/loop_kernel_arbiter.sv
// loop_kernel_arbiter
// Shares one in-order loop kernel between NREQ requesters: round-robin job
// issue, an in-order tag FIFO recording who issued each job, and steering of
// each kernel result back to the requester at the head of that FIFO.
// Optional build macro: LOOP_ARB_PERF_EN adds saturating 16-bit issue/return
// counters (perf_issued, perf_returned).
module loop_kernel_arbiter #(
  parameter int NREQ  = 4,
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ*W-1:0]       req_n,
  input  logic [NREQ-1:0]         req_vld,
  output logic [NREQ-1:0]         req_rdy,
  output logic [W-1:0]            resp_data,
  output logic [NREQ-1:0]         resp_vld,
  input  logic [NREQ-1:0]         resp_rdy,
  output logic [W-1:0]            k_n,
  output logic                    k_n_vld,
  input  logic                    k_n_rdy,
  input  logic [W-1:0]            k_result,
  input  logic                    k_result_vld,
  output logic                    k_result_rdy,
  output logic [$clog2(DEPTH):0]  inflight,
  output logic                    err_orphan
`ifdef LOOP_ARB_PERF_EN
  ,
  output logic [15:0]             perf_issued,
  output logic [15:0]             perf_returned
`endif
);

  localparam int TW = $clog2(NREQ);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = $clog2(DEPTH) + 1;

  logic [TW-1:0]   ptr_reg;
  logic [TW-1:0]   ptr_next;
  logic [TW-1:0]   grant;
  logic            any_vld;
  logic [TW:0]     scan_idx;
  logic [NREQ-1:0] grant_oh;
  logic [NREQ-1:0] head_oh;
  logic [W-1:0]    req_n_arr [NREQ];

  // Tag FIFO: pointers are one bit wider than needed only when DEPTH == 1.
  logic [TW-1:0]   tag_mem [0:(1<<AW)-1];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [IW-1:0]   inflight_reg;
  logic [TW-1:0]   head_tag;
  logic            err_orphan_reg;

  logic            full;
  logic            empty;
  logic            issue_fire;
  logic            ret_fire;

  // Unpack the flat operand bus into one slot per requester.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_n_arr[gi] = req_n[gi*W +: W];
    end
  endgenerate

  // Round-robin scan: first valid requester at or after ptr, wrapping at NREQ.
  always_comb begin
    grant    = ptr_reg;
    any_vld  = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = {1'b0, ptr_reg} + (TW+1)'(i);
      if (scan_idx >= (TW+1)'(NREQ))
        scan_idx = scan_idx - (TW+1)'(NREQ);
      if (!any_vld && req_vld[scan_idx[TW-1:0]]) begin
        any_vld = 1'b1;
        grant   = scan_idx[TW-1:0];
      end
    end
  end

  assign ptr_next = (grant == TW'(NREQ-1)) ? '0 : grant + 1'b1;
  assign grant_oh = {{(NREQ-1){1'b0}}, 1'b1} << grant;

  // Issue path: blocked purely on the registered count so a same-cycle pop
  // never feeds combinationally into a push.
  assign full       = (inflight_reg == IW'(DEPTH));
  assign empty      = (inflight_reg == '0);
  assign k_n_vld    = any_vld && !full;
  assign k_n        = req_n_arr[grant];
  assign issue_fire = k_n_vld && k_n_rdy;
  assign req_rdy    = issue_fire ? grant_oh : '0;

  // Return path: the head tag alone decides where the result goes.
  assign head_tag     = tag_mem[rd_ptr_reg];
  assign head_oh      = {{(NREQ-1){1'b0}}, 1'b1} << head_tag;
  assign resp_data    = k_result;
  assign resp_vld     = (!empty && k_result_vld) ? head_oh : '0;
  assign k_result_rdy = !empty && resp_rdy[head_tag];
  assign ret_fire     = k_result_vld && k_result_rdy;

  assign inflight   = inflight_reg;
  assign err_orphan = err_orphan_reg;

  // Control state: arbitration pointer, FIFO pointers, occupancy, orphan flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg        <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      inflight_reg   <= '0;
      err_orphan_reg <= 1'b0;
    end else begin
      if (issue_fire) begin
        ptr_reg    <= ptr_next;
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (ret_fire)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({issue_fire, ret_fire})
        2'b10:   inflight_reg <= inflight_reg + 1'b1;
        2'b01:   inflight_reg <= inflight_reg - 1'b1;
        default: inflight_reg <= inflight_reg;
      endcase
      if (empty && k_result_vld)
        err_orphan_reg <= 1'b1;
    end
  end

  // Tag storage: contents need no reset, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (issue_fire)
      tag_mem[wr_ptr_reg] <= grant;
  end

`ifdef LOOP_ARB_PERF_EN
  logic [15:0] perf_issued_reg;
  logic [15:0] perf_returned_reg;

  // Saturating activity counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued_reg   <= '0;
      perf_returned_reg <= '0;
    end else begin
      if (issue_fire && perf_issued_reg != 16'hFFFF)
        perf_issued_reg <= perf_issued_reg + 16'd1;
      if (ret_fire && perf_returned_reg != 16'hFFFF)
        perf_returned_reg <= perf_returned_reg + 16'd1;
    end
  end

  assign perf_issued   = perf_issued_reg;
  assign perf_returned = perf_returned_reg;
`endif

endmodule

// File: doc/loop_kernel_arbiter.md
# loop_kernel_arbiter

Shares one instance of the XLS-generated simple-loop kernel between NREQ independent requesters. Sits between the requester ports and the kernel's `n` input and `result` output channels. It round-robin arbitrates job issue, records the issuing requester in an in-order tag FIFO, and steers each kernel result back to the requester that issued the job. It replaces the single-shot go/started launch logic when more than one client needs the kernel.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 10, width of `n` and `result`
- DEPTH, 4, maximum jobs in flight (tag FIFO depth, power of two)

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset; also drives the kernel's rst
- req_n  in  NREQ*W  job operand, requester i at bits [i*W +: W]
- req_vld  in  NREQ  per-requester job valid
- req_rdy  out  NREQ  per-requester job accepted (one-hot or zero)
- resp_data  out  W  result being returned
- resp_vld  out  NREQ  one-hot: result is for requester i
- resp_rdy  in  NREQ  per-requester result ready
- k_n  out  W  operand to kernel `n` channel
- k_n_vld  out  1  kernel `n` valid
- k_n_rdy  in  1  kernel `n` ready
- k_result  in  W  kernel result
- k_result_vld  in  1  kernel result valid
- k_result_rdy  out  1  kernel result ready
- inflight  out  $clog2(DEPTH)+1  jobs issued, not yet returned
- err_orphan  out  1  sticky: kernel presented a result while no job was in flight

## Operation
- Issue arbitration: `grant` is the first requester with req_vld set, scanning from `ptr` upward modulo NREQ.
- `full` = (inflight == DEPTH). k_n_vld = |req_vld & !full; k_n = req_n slice of the granted requester.
- req_rdy[g] = k_n_vld & k_n_rdy for granted g only; all other bits 0.
- Issue fires when k_n_vld & k_n_rdy. On fire: push g into the tag FIFO and set ptr <= (g+1) mod NREQ.
- ptr holds when no issue fires. A requester holding req_vld is served within NREQ issues.
- Return path, FIFO non-empty with head tag h: resp_data = k_result; resp_vld = onehot(h) & {NREQ{k_result_vld}}; k_result_rdy = resp_rdy[h].
- Return fires when k_result_vld & k_result_rdy; it pops the FIFO.
- Return path, FIFO empty: k_result_rdy = 0, resp_vld = 0. If k_result_vld = 1, err_orphan <= 1 until rst.
- Results reach requesters in issue order; the kernel is in-order.
- inflight: +1 on issue fire, -1 on return fire, unchanged on both or neither.
- Full-FIFO rule: issue is blocked whenever inflight == DEPTH, even if a return fires in the same cycle. This gives DEPTH-deep throughput with no pop→push combinational path.

## Timing
- Zero added latency. Issue and return are combinational pass-throughs of valid/ready in the firing cycle.
- FIFO, ptr and inflight update on the next clk edge.
- req_vld must stay high with req_n stable until req_rdy is seen.
- resp_vld depends on k_result_vld and the head tag only, not on resp_rdy.
- Reset values: ptr = 0, FIFO empty, inflight = 0, err_orphan = 0. Hence req_rdy = 0, resp_vld = 0, k_n_vld = 0, k_result_rdy = 0 in the first cycle after reset until inputs drive them.
- Reset mid-operation: all in-flight tags are discarded. The kernel is reset by the same rst, so no result from before reset is delivered.
- Simultaneous issue and return in one cycle with inflight < DEPTH: both fire, inflight unchanged, FIFO read/write pointers both advance.

## Configuration
- LOOP_ARB_PERF_EN defined: adds outputs `perf_issued` and `perf_returned`, each 16 bits. They count issue and return fires, saturate at 16'hFFFF and clear on rst.
- LOOP_ARB_PERF_EN undefined: these ports and counters do not exist. Arbitration behaviour is identical either way.

## Test plan
- Single job: req_vld = 4'b0001, req_n[0] = 10'd7, kernel returns 10'd42 → one issue with k_n = 7. Then resp_vld = 4'b0001, resp_data = 42; inflight goes 0→1→0.
- Round-robin: all four req_vld held high, k_n_rdy = 1 → grant order 0,1,2,3,0 on consecutive issues.
- Full: DEPTH = 4 issues with k_result_vld = 0 → inflight = 4 and k_n_vld = 0. In the cycle of the first return, issue stays blocked; it resumes the cycle after.
- Ordering and backpressure: issue from requesters 2 then 1, with resp_rdy[2] = 0 for 5 cycles → k_result_rdy = 0 for those 5 cycles. The first result then goes to requester 2, the second to requester 1.
- Orphan: k_result_vld = 1 with inflight = 0 → k_result_rdy = 0 and err_orphan = 1 from the next cycle until rst.
- Reset mid-flight: rst asserted with inflight = 3 → next cycle inflight = 0, resp_vld = 0, ptr = 0. With LOOP_ARB_PERF_EN defined, perf counters also read 0.
